// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences the shared datapath through fetch,
// decode, execute, memory and write-back, and flags unsupported instructions.
module mc_ctrl #(
  parameter bit ENABLE_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_srca,
  output logic [1:0] alu_srcb,
  output logic [2:0] alu_op,
  output logic [1:0] EXTOp,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    ALU_WB   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WB   = 4'd7,
    MEM_WR   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_PASS = 3'b101;

  state_t state_q, state_d;

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == 6'b100001) || (f == 6'b100011) || (f == 6'b100100) ||
           (f == 6'b100101) || (f == 6'b101010);
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100011: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = FETCH;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    reg_write = 1'b0;
    reg_dst   = 2'b00;
    wd_sel    = 2'b00;
    alu_srca  = 1'b0;
    alu_srcb  = 2'b00;
    alu_op    = ALU_ADD;
    EXTOp     = 2'b11;
    illegal   = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req  = 1'b1;
        alu_srcb = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else begin
          state_d  = FETCH;
        end
      end
      DECODE: begin
        alu_srcb = 2'b11;
        // Unknown encodings either trap or fall back to fetching the next word.
        if (ENABLE_TRAP) state_d = TRAP;
        else             state_d = FETCH;
        case (op)
          OP_RTYPE: if (funct_ok(funct)) state_d = EXEC_R;
          OP_ORI, OP_LUI, OP_ADDIU: state_d = EXEC_I;
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_BEQ: state_d = BRANCH;
          OP_J:   state_d = JUMP;
          default: ;
        endcase
      end
      EXEC_R: begin
        alu_srca = 1'b1;
        alu_op   = funct_alu(funct);
        state_d  = ALU_WB;
      end
      EXEC_I: begin
        alu_srca = 1'b1;
        alu_srcb = 2'b10;
        if (op == OP_ORI) begin
          EXTOp  = 2'b00;
          alu_op = ALU_OR;
        end else if (op == OP_LUI) begin
          EXTOp  = 2'b10;
          alu_op = ALU_PASS;
        end
        state_d = ALU_WB;
      end
      ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (op == OP_RTYPE) ? 2'b01 : 2'b00;
        state_d   = FETCH;
      end
      MEM_ADDR: begin
        alu_srca = 1'b1;
        alu_srcb = 2'b10;
        state_d  = (op == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        state_d = mem_ready ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        reg_write = 1'b1;
        wd_sel    = 2'b01;
        state_d   = FETCH;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        state_d = mem_ready ? FETCH : MEM_WR;
      end
      BRANCH: begin
        alu_srca = 1'b1;
        alu_op   = ALU_SUB;
        pc_src   = 2'b01;
        pc_write = zero;
        state_d  = FETCH;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        state_d  = FETCH;
      end
      TRAP: begin
        illegal = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // Reset aborts any access in flight: no request, write or update escapes.
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign state = state_q;

endmodule
